// File: rtl/csr_counter_bank_pkg.sv
// csr_counter_bank_pkg
//   CSR address map, counter bit indices and mtpresc field positions shared by
//   the counter bank and its counter slices.
package csr_counter_bank_pkg;

  // Counter low/high halves. HPM counter n lives at base + n.
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MHPMCNT3  = 12'hB03;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHPMCNT3H = 12'hB83;

  localparam logic [11:0] CSR_MCOUNTINH = 12'h320;
  localparam logic [11:0] CSR_MHPMEVT3  = 12'h323;

  localparam logic [11:0] CSR_MTIME     = 12'hBC0;
  localparam logic [11:0] CSR_MTIMEH    = 12'hBC1;
  localparam logic [11:0] CSR_MTIMECMP  = 12'hBC2;  // channel k: +2k lo, +2k+1 hi
  localparam logic [11:0] CSR_MTPRESC   = 12'hBD0;
  localparam logic [11:0] CSR_MCNTOVF   = 12'hBD1;

  // Bit positions shared by mcountinhibit and mcntovf.
  localparam int INH_CY   = 0;
  localparam int INH_IR   = 2;
  localparam int INH_HPM3 = 3;

  // mtpresc fields: [31] enable, [PRESC_W-1:0] divide value.
  localparam int PRESC_EN_BIT = 31;

  // Slice j -> inhibit/overflow bit: 0 = mcycle, 1 = minstret, 2+i = hpm(3+i).
  // The same value is the CSR address offset from mcycle/mcycleh.
  function automatic int cnt_bit(input int j);
    return (j == 0) ? INH_CY : (j == 1) ? INH_IR : INH_HPM3 + j - 2;
  endfunction

  // Writable bits of mcountinhibit / mcntovf.
  function automatic logic [31:0] cnt_mask(input int num_hpm);
    logic [31:0] m;
    m = '0;
    m[INH_CY] = 1'b1;
    m[INH_IR] = 1'b1;
    for (int i = 0; i < num_hpm; i++) m[INH_HPM3 + i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/csr_counter_bank_cnt_slice.sv
// csr_cnt_slice
//   One CNT_W-bit counter with independently writable 32-bit halves.
//   A write to either half suppresses the increment for that cycle; the
//   unwritten half holds.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   i_inc           count enable for this cycle
//   i_we_lo/i_we_hi write low / high half
//   i_wdata         write data
//   o_value         current counter value
//   o_wrap          high in the cycle an increment rolls all-ones to zero
module csr_cnt_slice #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_we_lo,
  input  logic             i_we_hi,
  input  logic [31:0]      i_wdata,
  output logic [CNT_W-1:0] o_value,
  output logic             o_wrap
);
  localparam int HI_W = CNT_W - 32;

  logic [CNT_W-1:0] r_value;
  logic             w_we;

  assign w_we    = i_we_lo | i_we_hi;
  assign o_wrap  = i_inc & ~w_we & (&r_value);
  assign o_value = r_value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= '0;
    end else if (w_we) begin
      if (i_we_lo) r_value[31:0]       <= i_wdata;
      if (i_we_hi) r_value[CNT_W-1:32] <= i_wdata[HI_W-1:0];
    end else if (i_inc) begin
      r_value <= r_value + CNT_W'(1);
    end
  end
endmodule

// File: rtl/csr_counter_bank.sv
// csr_counter_bank
//   Machine counter/timer CSR bank: mcycle, minstret, NUM_HPM event counters
//   with selectors, mcountinhibit, mcntovf (W1C), and a prescaled 64-bit mtime
//   with NUM_TCMP compare channels.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   csr_we_i/addr_i/wdata_i      CSR write channel
//   csr_rdata_o, csr_hit_o       combinational read data / address decode hit
//   instret_i                    retire pulse for minstret
//   ev_i                         event pulses for the HPM counters
//   tcmp_irq_o                   registered mtime >= mtimecmp[k]
//   ovf_irq_o                    registered |mcntovf
//   mtime_o                      current mtime
module csr_counter_bank
  import csr_counter_bank_pkg::*;
#(
  parameter int NUM_HPM    = 4,
  parameter int NUM_EVENTS = 8,
  parameter int CNT_W      = 64,
  parameter int NUM_TCMP   = 2,
  parameter int PRESC_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  csr_we_i,
  input  logic [11:0]           csr_addr_i,
  input  logic [31:0]           csr_wdata_i,
  output logic [31:0]           csr_rdata_o,
  output logic                  csr_hit_o,
  input  logic                  instret_i,
  input  logic [NUM_EVENTS-1:0] ev_i,
  output logic [NUM_TCMP-1:0]   tcmp_irq_o,
  output logic                  ovf_irq_o,
  output logic [63:0]           mtime_o
);
  localparam int          NCNT     = 2 + NUM_HPM;
  localparam int          EV_W     = $clog2(NUM_EVENTS + 1);
  localparam logic [31:0] CNT_MASK = cnt_mask(NUM_HPM);

  // ---------------- counters ----------------
  logic [NCNT-1:0]            w_inc, w_we_lo, w_we_hi, w_wrap;
  logic [NCNT-1:0][CNT_W-1:0] w_val;
  logic [NUM_HPM-1:0]         w_ev_hit;
  logic [NUM_HPM-1:0][EV_W-1:0] r_evsel;
  logic [31:0]                r_inhibit, r_ovf, w_ovf_set, w_ovf_clr;
  logic                       r_ovf_irq;

  // Selector values outside 1..NUM_EVENTS match no event bit and never count.
  always_comb begin
    w_ev_hit = '0;
    for (int i = 0; i < NUM_HPM; i++)
      for (int e = 0; e < NUM_EVENTS; e++)
        if (r_evsel[i] == EV_W'(e + 1) && ev_i[e]) w_ev_hit[i] = 1'b1;
  end

  for (genvar j = 0; j < NCNT; j++) begin : g_cnt
    localparam int B = cnt_bit(j);
    assign w_we_lo[j] = csr_we_i && (csr_addr_i == CSR_MCYCLE  + 12'(B));
    assign w_we_hi[j] = csr_we_i && (csr_addr_i == CSR_MCYCLEH + 12'(B));
    if (j == 0) begin : g_cy
      assign w_inc[j] = ~r_inhibit[B];
    end else if (j == 1) begin : g_ir
      assign w_inc[j] = instret_i & ~r_inhibit[B];
    end else begin : g_hpm
      assign w_inc[j] = w_ev_hit[j-2] & ~r_inhibit[B];
    end
    csr_cnt_slice #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_inc   (w_inc[j]),
      .i_we_lo (w_we_lo[j]),
      .i_we_hi (w_we_hi[j]),
      .i_wdata (csr_wdata_i),
      .o_value (w_val[j]),
      .o_wrap  (w_wrap[j])
    );
  end

  always_comb begin
    w_ovf_set = '0;
    for (int j = 0; j < NCNT; j++)
      if (w_wrap[j]) w_ovf_set[cnt_bit(j)] = 1'b1;
  end

  assign w_ovf_clr = (csr_we_i && csr_addr_i == CSR_MCNTOVF) ? csr_wdata_i : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inhibit <= '0;
      r_ovf     <= '0;
      r_ovf_irq <= 1'b0;
      r_evsel   <= '0;
    end else begin
      // Set wins over a same-cycle W1C.
      r_ovf     <= (r_ovf & ~w_ovf_clr) | w_ovf_set;
      r_ovf_irq <= |r_ovf;
      if (csr_we_i && csr_addr_i == CSR_MCOUNTINH) r_inhibit <= csr_wdata_i & CNT_MASK;
      for (int i = 0; i < NUM_HPM; i++)
        if (csr_we_i && csr_addr_i == CSR_MHPMEVT3 + 12'(i))
          r_evsel[i] <= csr_wdata_i[EV_W-1:0];
    end
  end

  // ---------------- timer ----------------
  logic                          r_presc_en;
  logic [PRESC_W-1:0]            r_presc_div, r_presc_cnt;
  logic [63:0]                   r_mtime;
  logic [NUM_TCMP-1:0][63:0]     r_mtimecmp;
  logic [NUM_TCMP-1:0]           r_tcmp_irq;
  logic                          w_presc_we, w_tick;

  assign w_presc_we = csr_we_i && (csr_addr_i == CSR_MTPRESC);
  // A write to mtpresc restarts the divider; no tick in that cycle.
  assign w_tick = r_presc_en && (r_presc_cnt == r_presc_div) && !w_presc_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc_en  <= 1'b0;
      r_presc_div <= '0;
      r_presc_cnt <= '0;
      r_mtime     <= '0;
      r_mtimecmp  <= '1;
      r_tcmp_irq  <= '0;
    end else begin
      if (w_presc_we) begin
        r_presc_en  <= csr_wdata_i[PRESC_EN_BIT];
        r_presc_div <= csr_wdata_i[PRESC_W-1:0];
        r_presc_cnt <= '0;
      end else if (r_presc_en) begin
        r_presc_cnt <= (r_presc_cnt == r_presc_div) ? '0 : r_presc_cnt + PRESC_W'(1);
      end

      if (csr_we_i && (csr_addr_i == CSR_MTIME || csr_addr_i == CSR_MTIMEH)) begin
        if (csr_addr_i == CSR_MTIME) r_mtime[31:0]  <= csr_wdata_i;
        else                         r_mtime[63:32] <= csr_wdata_i;
      end else if (w_tick) begin
        r_mtime <= r_mtime + 64'd1;
      end

      for (int k = 0; k < NUM_TCMP; k++) begin
        r_tcmp_irq[k] <= (r_mtime >= r_mtimecmp[k]);
        if (csr_we_i && csr_addr_i == CSR_MTIMECMP + 12'(2*k))
          r_mtimecmp[k][31:0] <= csr_wdata_i;
        if (csr_we_i && csr_addr_i == CSR_MTIMECMP + 12'(2*k + 1))
          r_mtimecmp[k][63:32] <= csr_wdata_i;
      end
    end
  end

  // ---------------- read mux ----------------
  always_comb begin
    csr_rdata_o = '0;
    csr_hit_o   = 1'b0;
    for (int j = 0; j < NCNT; j++) begin
      if (csr_addr_i == CSR_MCYCLE + 12'(cnt_bit(j))) begin
        csr_hit_o = 1'b1; csr_rdata_o = w_val[j][31:0];
      end
      if (csr_addr_i == CSR_MCYCLEH + 12'(cnt_bit(j))) begin
        csr_hit_o = 1'b1; csr_rdata_o = 32'(w_val[j][CNT_W-1:32]);
      end
    end
    for (int i = 0; i < NUM_HPM; i++)
      if (csr_addr_i == CSR_MHPMEVT3 + 12'(i)) begin
        csr_hit_o = 1'b1; csr_rdata_o = 32'(r_evsel[i]);
      end
    for (int k = 0; k < NUM_TCMP; k++) begin
      if (csr_addr_i == CSR_MTIMECMP + 12'(2*k)) begin
        csr_hit_o = 1'b1; csr_rdata_o = r_mtimecmp[k][31:0];
      end
      if (csr_addr_i == CSR_MTIMECMP + 12'(2*k + 1)) begin
        csr_hit_o = 1'b1; csr_rdata_o = r_mtimecmp[k][63:32];
      end
    end
    case (csr_addr_i)
      CSR_MCOUNTINH: begin csr_hit_o = 1'b1; csr_rdata_o = r_inhibit; end
      CSR_MCNTOVF:   begin csr_hit_o = 1'b1; csr_rdata_o = r_ovf; end
      CSR_MTIME:     begin csr_hit_o = 1'b1; csr_rdata_o = r_mtime[31:0]; end
      CSR_MTIMEH:    begin csr_hit_o = 1'b1; csr_rdata_o = r_mtime[63:32]; end
      CSR_MTPRESC: begin
        csr_hit_o = 1'b1;
        csr_rdata_o[PRESC_EN_BIT]  = r_presc_en;
        csr_rdata_o[PRESC_W-1:0]   = r_presc_div;
      end
      default: ;
    endcase
  end

  assign tcmp_irq_o = r_tcmp_irq;
  assign ovf_irq_o  = r_ovf_irq;
  assign mtime_o    = r_mtime;

endmodule

// File: doc/csr_counter_bank.md
Name: csr_counter_bank

Overview:
Parametrised machine counter/timer CSR bank that replaces the fixed mtime/minstret/mtimecmp logic of the core CSR file.
- Provides mcycle, minstret, NUM_HPM event counters with event selectors, mcountinhibit, and an overflow status register.
- Provides a prescaled 64-bit mtime with NUM_TCMP compare channels.
- Sits beside the CSR file on the execute-stage CSR access channel; the CSR file ORs csr_rdata_o into its read mux when csr_hit_o is high.

Parameters:
NUM_HPM, 4, number of mhpmcounter/mhpmevent pairs (1..29), numbered 3..3+NUM_HPM-1
NUM_EVENTS, 8, width of the ev_i event vector (1..255)
CNT_W, 64, width of mcycle/minstret/hpm counters (33..64); unimplemented upper bits read 0
NUM_TCMP, 2, number of mtimecmp channels (1..4)
PRESC_W, 16, mtime prescaler width (1..31)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
csr_we_i  in  1  CSR write enable, synchronous
csr_addr_i  in  12  CSR address
csr_wdata_i  in  32  CSR write data
csr_rdata_o  out  32  CSR read data, combinational from csr_addr_i
csr_hit_o  out  1  csr_addr_i decodes to a register in this block
instret_i  in  1  one-cycle pulse per retired instruction
ev_i  in  NUM_EVENTS  event pulses; each bit counts one event per cycle when high
tcmp_irq_o  out  NUM_TCMP  registered timer interrupt per channel
ovf_irq_o  out  1  registered OR of mcntovf
mtime_o  out  64  current mtime value

Behaviour:
- Reset values:
  - All counters, mtime, mhpmevent*, mcountinhibit, mcntovf, mtpresc and the prescaler count reset to 0.
  - mtimecmp[k] resets to all-ones.
  - tcmp_irq_o = 0, ovf_irq_o = 0.
- Address map (package constants):
  - mcycle B00/B80, minstret B02/B82, mhpmcounter(3+i) B03+i / B83+i.
  - mhpmevent(3+i) 323+i, mcountinhibit 320.
  - mtime BC0/BC1, mtimecmp[k] BC2+2k / BC3+2k.
  - mtpresc BD0: [31] = enable, [PRESC_W-1:0] = divide value.
  - mcntovf BD1: write-1-to-clear.
- Reads: combinational, return pre-write (current) state; unmapped address -> 0 with csr_hit_o = 0. High halves return counter bits [CNT_W-1:32] zero-extended.
- mcountinhibit bits: [0] = CY, [2] = IR, [3+i] = HPM i. Writable; all other bits read 0.
- Increment sources, each gated by its inhibit bit:
  - mcycle: every cycle.
  - minstret: when instret_i is high.
  - hpm i: when mhpmevent = v, 1 <= v <= NUM_EVENTS, and ev_i[v-1] is high. v = 0 or v > NUM_EVENTS never counts.
  - mhpmevent stores clog2(NUM_EVENTS+1) bits; upper bits read 0.
- Write vs increment in the same cycle: the write wins for the written half. The unwritten half keeps its value and the increment is dropped; no carry from the dropped increment.
- Overflow: an increment from all-ones (CNT_W bits) wraps to 0 and sets the mcntovf bit at that counter's mcountinhibit index on the same edge. A W1C in the same cycle as a set leaves the bit set. ovf_irq_o = |mcntovf.
- Timer:
  - With the enable bit at 1, the prescaler count increments each cycle.
  - When count == divide value, count returns to 0 and mtime increments, so the tick period is divide+1 cycles; divide 0 gives a tick every cycle.
  - Writing mtpresc clears the count.
  - Writing an mtime half overrides the tick in that cycle; the other half holds.
  - mtime always wraps at 64 bits, with no overflow flag.
- Compare: tcmp_irq_o[k] is registered (mtime >= mtimecmp[k]), an unsigned 64-bit comparison, so it lags the condition by 1 cycle. It is level, and clears only when mtimecmp is raised above mtime or mtime is rewritten below it.
- Reset mid-operation: everything returns to reset values asynchronously; no pending increment survives.

Decomposition:
- Shared package holds the CSR address constants listed above, the mcountinhibit/mcntovf bit indices, and the mtpresc field positions.
- Sub-module csr_cnt_slice holds one CNT_W counter. Inputs: inc, we_lo, we_hi, wdata. Outputs: value, wrap pulse. It is instantiated 2+NUM_HPM times.
- Timer, prescaler and comparators stay in the top module.

Test Plan:
- Reset -> every mapped counter reads 0; mtimecmp0/0h read FFFFFFFF; tcmp_irq_o = 0, ovf_irq_o = 0; address 0x123 returns 0 with csr_hit_o = 0.
- Carry into high half: write mcycle = FFFFFFFE, mcycleh = 0 -> one cycle later mcycle reads FFFFFFFF; the next cycle mcycle reads 0 and mcycleh reads 1. The write-cycle increment is lost: write 100 while counting -> reads 100, then 101.
- Event select and inhibit:
  - mhpmevent3 = 2; ev_i[1] high 5 cycles, ev_i[0] high 3 cycles -> mhpmcounter3 = 5.
  - Set mcountinhibit bit 3, pulse ev_i[1] 4 cycles -> still 5.
  - mhpmevent3 = 9 with NUM_EVENTS = 8 -> never counts.
- Overflow: mhpmcounter4 = FFFFFFFF_FFFFFFFF, mhpmevent4 = 1, one ev_i[0] pulse -> counter 0, mcntovf = 0x10, ovf_irq_o = 1 the next cycle. Write mcntovf = 0x10 -> 0, and irq drops.
- Timer: mtimecmp0 = 5, mtimecmp0h = 0, mtpresc = 0x80000003 -> mtime increments every 4 cycles; tcmp_irq_o[0] rises 1 cycle after mtime = 5, and tcmp_irq_o[1] stays 0. Writing mtimecmp0 = 100 clears the irq one cycle later.
- Async reset asserted mid-count with irqs high -> all outputs 0 immediately; the counters restart from 0 after release.
